intersection_phase_scheduler: RTL and testbench

Right-of-way scheduler for the four-way intersection. It arbitrates three requesters for the shared intersection: North-South traffic, East-West traffic and the pedestrian crossing. It sequences green, yellow, all-red and walk phases with a per-phase down-counter and drives the NS/EW lamp heads directly. One clock cycle equals one second of signal time, matching the existing lamp-timing convention.

---
 rtl/intersection_phase_scheduler_if.sv | 24 ++
 rtl/intersection_phase_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/intersection_phase_scheduler_if.sv
// rtl/intersection_phase_scheduler_if.sv - request inputs and lamp/status outputs of the phase scheduler
interface intersection_phase_scheduler_if #(
  parameter int CW = 4
);
  logic          NS_req;
  logic          EW_req;
  logic          ped_req;
  logic [2:0]    NS_light;
  logic [2:0]    EW_light;
  logic          walk;
  logic          ped_ack;
  logic [2:0]    phase;
  logic [CW-1:0] timer;

  modport master (
    output NS_req, EW_req, ped_req,
    input  NS_light, EW_light, walk, ped_ack, phase, timer
  );

  modport slave (
    input  NS_req, EW_req, ped_req,
    output NS_light, EW_light, walk, ped_ack, phase, timer
  );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - NS/EW/pedestrian right-of-way scheduler, one cycle per second
// Optional pedestrian phase enabled by defining PED_PHASE_EN.
module intersection_phase_scheduler #(
  parameter int GREEN_MAX = 10,
  parameter int GREEN_MIN = 5,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CW        = 4
) (
  input logic                           clk,
  input logic                           rst,
  intersection_phase_scheduler_if.slave bus
);
  typedef enum logic [2:0] {
    ALL_RED   = 3'b000,
    NS_GREEN  = 3'b001,
    NS_YELLOW = 3'b010,
    EW_GREEN  = 3'b011,
`ifdef PED_PHASE_EN
    EW_YELLOW = 3'b100,
    WALK      = 3'b101
`else
    EW_YELLOW = 3'b100
`endif
  } phase_e;

  typedef enum logic [1:0] {
    SRC_NS  = 2'd0,
    SRC_EW  = 2'd1,
    SRC_PED = 2'd2
  } src_e;

  localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LD = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] GAP_TH    = CW'(GREEN_MAX - GREEN_MIN);
`ifdef PED_PHASE_EN
  localparam logic [CW-1:0] WALK_LD   = CW'(WALK_T - 1);
  localparam src_e          LAST_RST  = SRC_PED;
`else
  localparam src_e          LAST_RST  = SRC_EW;
`endif

  phase_e        phase_q, phase_d;
  logic [CW-1:0] timer_q, timer_d;
  src_e          last_q, last_d;
  logic          ns_pend_q, ns_pend_d;
  logic          ew_pend_q, ew_pend_d;
  src_e          grant;
  logic          ns_other, ew_other;
  logic          gap_ok;

`ifdef PED_PHASE_EN
  logic          ped_pend_q, ped_pend_d;
  logic          ped_ack_q, ped_ack_d;

  assign ns_other = ew_pend_q | ped_pend_q;
  assign ew_other = ns_pend_q | ped_pend_q;

  always_comb begin
    grant = SRC_NS;
    case (last_q)
      SRC_NS:  grant = ew_pend_q ? SRC_EW : ped_pend_q ? SRC_PED : ns_pend_q ? SRC_NS : SRC_EW;
      SRC_EW:  grant = ped_pend_q ? SRC_PED : ns_pend_q ? SRC_NS : ew_pend_q ? SRC_EW : SRC_NS;
      default: grant = ns_pend_q ? SRC_NS : ew_pend_q ? SRC_EW : ped_pend_q ? SRC_PED : SRC_NS;
    endcase
  end
`else
  logic unused_ped;
  assign unused_ped = bus.ped_req;
  assign ns_other   = ew_pend_q;
  assign ew_other   = ns_pend_q;

  always_comb begin
    grant = SRC_NS;
    case (last_q)
      SRC_NS:  grant = ew_pend_q ? SRC_EW : ns_pend_q ? SRC_NS : SRC_EW;
      default: grant = ns_pend_q ? SRC_NS : ew_pend_q ? SRC_EW : SRC_NS;
    endcase
  end
`endif

  // Gap-out window opens once GREEN_MIN cycles of green have been served.
  assign gap_ok = (timer_q <= GAP_TH);

  always_comb begin
    phase_d = phase_q;
    timer_d = (timer_q != '0) ? timer_q - CW'(1) : timer_q;
    last_d  = last_q;
`ifdef PED_PHASE_EN
    ped_ack_d = 1'b0;
`endif
    case (phase_q)
      ALL_RED: if (timer_q == '0) begin
        last_d = grant;
        case (grant)
          SRC_NS:  begin phase_d = NS_GREEN; timer_d = GREEN_LD; end
`ifdef PED_PHASE_EN
          SRC_EW:  begin phase_d = EW_GREEN; timer_d = GREEN_LD; end
          default: begin phase_d = WALK;     timer_d = WALK_LD; ped_ack_d = 1'b1; end
`else
          default: begin phase_d = EW_GREEN; timer_d = GREEN_LD; end
`endif
        endcase
      end
      NS_GREEN: if (timer_q == '0 || (gap_ok && !bus.NS_req && ns_other)) begin
        phase_d = NS_YELLOW;
        timer_d = YELLOW_LD;
      end
      EW_GREEN: if (timer_q == '0 || (gap_ok && !bus.EW_req && ew_other)) begin
        phase_d = EW_YELLOW;
        timer_d = YELLOW_LD;
      end
      NS_YELLOW, EW_YELLOW: if (timer_q == '0) begin
        phase_d = ALL_RED;
        timer_d = ALLRED_LD;
      end
`ifdef PED_PHASE_EN
      WALK: if (timer_q == '0) begin
        phase_d = ALL_RED;
        timer_d = ALLRED_LD;
      end
`endif
      default: begin
        phase_d = ALL_RED;
        timer_d = ALLRED_LD;
      end
    endcase
  end

  // Entry into a requester's own phase clears its latch even if it is requesting again.
  always_comb begin
    ns_pend_d = (ns_pend_q | (bus.NS_req & (phase_q != NS_GREEN) & (phase_q != NS_YELLOW)))
                & ~((phase_d == NS_GREEN) & (phase_q != NS_GREEN));
    ew_pend_d = (ew_pend_q | (bus.EW_req & (phase_q != EW_GREEN) & (phase_q != EW_YELLOW)))
                & ~((phase_d == EW_GREEN) & (phase_q != EW_GREEN));
`ifdef PED_PHASE_EN
    ped_pend_d = (ped_pend_q | (bus.ped_req & (phase_q != WALK)))
                 & ~((phase_d == WALK) & (phase_q != WALK));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= ALL_RED;
      timer_q    <= ALLRED_LD;
      last_q     <= LAST_RST;
      ns_pend_q  <= 1'b0;
      ew_pend_q  <= 1'b0;
`ifdef PED_PHASE_EN
      ped_pend_q <= 1'b0;
      ped_ack_q  <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      timer_q    <= timer_d;
      last_q     <= last_d;
      ns_pend_q  <= ns_pend_d;
      ew_pend_q  <= ew_pend_d;
`ifdef PED_PHASE_EN
      ped_pend_q <= ped_pend_d;
      ped_ack_q  <= ped_ack_d;
`endif
    end
  end

  always_comb begin
    bus.NS_light = 3'b100;
    bus.EW_light = 3'b100;
    case (phase_q)
      NS_GREEN:  bus.NS_light = 3'b001;
      NS_YELLOW: bus.NS_light = 3'b010;
      EW_GREEN:  bus.EW_light = 3'b001;
      EW_YELLOW: bus.EW_light = 3'b010;
      default:   ;
    endcase
  end

  assign bus.phase = phase_q;
  assign bus.timer = timer_q;
`ifdef PED_PHASE_EN
  assign bus.walk    = (phase_q == WALK);
  assign bus.ped_ack = ped_ack_q;
`else
  assign bus.walk    = 1'b0;
  assign bus.ped_ack = 1'b0;
`endif
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed self-checking bench for intersection_phase_scheduler
module tb_intersection_phase_scheduler;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  intersection_phase_scheduler_if #(.CW(CW)) bus ();
  intersection_phase_scheduler #(
    .GREEN_MAX(10), .GREEN_MIN(5), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(6), .CW(CW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PED_PHASE_EN
  intersection_phase_scheduler_if #(.CW(CW)) bus2 ();
  intersection_phase_scheduler #(
    .GREEN_MAX(10), .GREEN_MIN(5), .YELLOW_T(2), .ALLRED_T(2), .WALK_T(6), .CW(CW)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ns_lamp(input logic [2:0] ph);
    return (ph == 3'd1) ? 3'b001 : (ph == 3'd2) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] ew_lamp(input logic [2:0] ph);
    return (ph == 3'd3) ? 3'b001 : (ph == 3'd4) ? 3'b010 : 3'b100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.NS_req = 1'b0; bus.EW_req = 1'b0; bus.ped_req = 1'b0;
`ifdef PED_PHASE_EN
    bus2.NS_req = 1'b0; bus2.EW_req = 1'b0; bus2.ped_req = 1'b0;
`endif
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.NS_req = 1'b0; bus.EW_req = 1'b0; bus.ped_req = 1'b0;
`ifdef PED_PHASE_EN
    bus2.NS_req = 1'b0; bus2.EW_req = 1'b0; bus2.ped_req = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.phase !== 3'd0) $display("FAIL reset_phase: got %0d expected 0", bus.phase); else passed++;
    total++;
    if (bus.timer !== 4'd0) $display("FAIL reset_timer: got %0d expected 0", bus.timer); else passed++;
    total++;
    if (bus.NS_light !== 3'b100 || bus.EW_light !== 3'b100)
      $display("FAIL reset_lamps: got %b/%b expected 100/100", bus.NS_light, bus.EW_light);
    else passed++;
    total++;
    if (bus.walk !== 1'b0 || bus.ped_ack !== 1'b0)
      $display("FAIL reset_walk: got walk=%b ack=%b expected 0/0", bus.walk, bus.ped_ack);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_default_cycle();
    logic [2:0] ph  [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd1};
    int         st  [8] = '{0, 9, 1, 0, 9, 1, 0, 9};
    int         len [8] = '{1, 10, 2, 1, 10, 2, 1, 1};
    do_reset();
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        total++;
        if (bus.phase !== ph[s] || bus.timer !== CW'(st[s] - i) || bus.NS_light !== ns_lamp(ph[s]) ||
            bus.EW_light !== ew_lamp(ph[s]) || bus.walk !== 1'b0 || bus.ped_ack !== 1'b0)
          $display("FAIL default_cycle seg%0d cyc%0d: phase=%0d timer=%0d lamps=%b/%b walk=%b expected phase=%0d timer=%0d lamps=%b/%b walk=0",
                   s, i, bus.phase, bus.timer, bus.NS_light, bus.EW_light, bus.walk,
                   ph[s], st[s] - i, ns_lamp(ph[s]), ew_lamp(ph[s]));
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_gap_out();
    logic [2:0] ph  [4] = '{3'd1, 3'd2, 3'd0, 3'd3};
    int         st  [4] = '{9, 1, 0, 9};
    int         len [4] = '{5, 2, 1, 1};
    do_reset();
    tick();
    bus.NS_req = 1'b0;
    bus.EW_req = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        total++;
        if (bus.phase !== ph[s] || bus.timer !== CW'(st[s] - i) ||
            bus.NS_light !== ns_lamp(ph[s]) || bus.EW_light !== ew_lamp(ph[s]))
          $display("FAIL ns_gap_out seg%0d cyc%0d: phase=%0d timer=%0d lamps=%b/%b expected phase=%0d timer=%0d lamps=%b/%b",
                   s, i, bus.phase, bus.timer, bus.NS_light, bus.EW_light,
                   ph[s], st[s] - i, ns_lamp(ph[s]), ew_lamp(ph[s]));
        else passed++;
        tick();
      end
    end
    bus.EW_req = 1'b0;
  endtask

  task automatic test_ew_gap_out();
    logic [2:0] ph  [4] = '{3'd3, 3'd4, 3'd0, 3'd1};
    int         st  [4] = '{9, 1, 0, 9};
    int         len [4] = '{5, 2, 1, 1};
    do_reset();
    repeat (14) tick();
    bus.NS_req = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        total++;
        if (bus.phase !== ph[s] || bus.timer !== CW'(st[s] - i))
          $display("FAIL ew_gap_out seg%0d cyc%0d: phase=%0d timer=%0d expected phase=%0d timer=%0d",
                   s, i, bus.phase, bus.timer, ph[s], st[s] - i);
        else passed++;
        tick();
      end
    end
    bus.NS_req = 1'b0;
  endtask

  task automatic test_reset_mid_phase();
    do_reset();
    tick();
    bus.NS_req = 1'b1;
    bus.EW_req = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.phase !== 3'd1 || bus.timer !== 4'd6)
      $display("FAIL midreset_pre: phase=%0d timer=%0d expected phase=1 timer=6", bus.phase, bus.timer);
    else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.NS_light !== 3'b100 || bus.EW_light !== 3'b100 || bus.walk !== 1'b0)
      $display("FAIL midreset_lamps: got %b/%b walk=%b expected 100/100 walk=0", bus.NS_light, bus.EW_light, bus.walk);
    else passed++;
    total++;
    if (bus.phase !== 3'd0 || bus.timer !== 4'd0)
      $display("FAIL midreset_state: phase=%0d timer=%0d expected phase=0 timer=0", bus.phase, bus.timer);
    else passed++;
    total++;
    if (dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0)
      $display("FAIL midreset_latches: ns=%b ew=%b expected 0/0", dut.ns_pend_q, dut.ew_pend_q);
    else passed++;
    total++;
`ifdef PED_PHASE_EN
    if (dut.last_q !== 2'd2) $display("FAIL midreset_last: got %0d expected 2", dut.last_q); else passed++;
`else
    if (dut.last_q !== 2'd1) $display("FAIL midreset_last: got %0d expected 1", dut.last_q); else passed++;
`endif
    bus.NS_req = 1'b0;
    bus.EW_req = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (bus.phase !== 3'd0 || bus.timer !== 4'd0)
      $display("FAIL midreset_release: phase=%0d timer=%0d expected phase=0 timer=0", bus.phase, bus.timer);
    else passed++;
    tick();
    total++;
    if (bus.phase !== 3'd1 || bus.timer !== 4'd9 || bus.NS_light !== 3'b001)
      $display("FAIL midreset_grant: phase=%0d timer=%0d ns=%b expected phase=1 timer=9 ns=001",
               bus.phase, bus.timer, bus.NS_light);
    else passed++;
  endtask

`ifdef PED_PHASE_EN
  task automatic test_walk();
    logic [2:0] ph  [6] = '{3'd3, 3'd4, 3'd0, 3'd5, 3'd0, 3'd1};
    int         st  [6] = '{8, 1, 0, 5, 0, 9};
    int         len [6] = '{4, 2, 1, 6, 1, 1};
    logic       exp_walk, exp_ack;
    do_reset();
    repeat (14) tick();
    bus.ped_req = 1'b1;
    tick();
    bus.ped_req = 1'b0;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        exp_walk = (ph[s] == 3'd5);
        exp_ack  = (ph[s] == 3'd5) && (i == 0);
        total++;
        if (bus.phase !== ph[s] || bus.timer !== CW'(st[s] - i) || bus.walk !== exp_walk ||
            bus.ped_ack !== exp_ack || bus.NS_light !== ns_lamp(ph[s]) || bus.EW_light !== ew_lamp(ph[s]))
          $display("FAIL walk_seq seg%0d cyc%0d: phase=%0d timer=%0d walk=%b ack=%b lamps=%b/%b expected phase=%0d timer=%0d walk=%b ack=%b lamps=%b/%b",
                   s, i, bus.phase, bus.timer, bus.walk, bus.ped_ack, bus.NS_light, bus.EW_light,
                   ph[s], st[s] - i, exp_walk, exp_ack, ns_lamp(ph[s]), ew_lamp(ph[s]));
        else passed++;
        tick();
      end
    end
  endtask

  task automatic test_all_pending();
    do_reset();
    repeat (16) tick();
    total++;
    if (bus2.phase !== 3'd3 || bus2.timer !== 4'd9)
      $display("FAIL allpend_ewgreen: phase=%0d timer=%0d expected phase=3 timer=9", bus2.phase, bus2.timer);
    else passed++;
    bus2.NS_req  = 1'b1;
    bus2.EW_req  = 1'b1;
    bus2.ped_req = 1'b1;
    tick();
    bus2.ped_req = 1'b0;
    bus2.NS_req  = 1'b0;
    repeat (11) tick();
    total++;
    if (bus2.phase !== 3'd0 || bus2.timer !== 4'd1)
      $display("FAIL allpend_allred: phase=%0d timer=%0d expected phase=0 timer=1", bus2.phase, bus2.timer);
    else passed++;
    tick();
    total++;
    if (dut2.ns_pend_q !== 1'b1 || dut2.ew_pend_q !== 1'b1 || dut2.ped_pend_q !== 1'b1 || dut2.last_q !== 2'd1)
      $display("FAIL allpend_latches: ns=%b ew=%b ped=%b last=%0d expected 1/1/1 last=1",
               dut2.ns_pend_q, dut2.ew_pend_q, dut2.ped_pend_q, dut2.last_q);
    else passed++;
    tick();
    total++;
    if (bus2.phase !== 3'd5 || bus2.walk !== 1'b1 || bus2.ped_ack !== 1'b1 || bus2.timer !== 4'd5)
      $display("FAIL allpend_grant: phase=%0d walk=%b ack=%b timer=%0d expected phase=5 walk=1 ack=1 timer=5",
               bus2.phase, bus2.walk, bus2.ped_ack, bus2.timer);
    else passed++;
    bus2.EW_req = 1'b0;
  endtask
`else
  task automatic test_no_ped();
    logic [2:0] ph  [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4, 3'd0, 3'd1};
    int         st  [8] = '{0, 9, 1, 0, 9, 1, 0, 9};
    int         len [8] = '{1, 10, 2, 1, 10, 2, 1, 1};
    do_reset();
    bus.ped_req = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        total++;
        if (bus.phase !== ph[s] || bus.timer !== CW'(st[s] - i) || bus.walk !== 1'b0 || bus.ped_ack !== 1'b0)
          $display("FAIL no_ped seg%0d cyc%0d: phase=%0d timer=%0d walk=%b ack=%b expected phase=%0d timer=%0d walk=0 ack=0",
                   s, i, bus.phase, bus.timer, bus.walk, bus.ped_ack, ph[s], st[s] - i);
        else passed++;
        tick();
      end
    end
    bus.ped_req = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    test_reset();
    test_default_cycle();
    test_gap_out();
    test_ew_gap_out();
    test_reset_mid_phase();
`ifdef PED_PHASE_EN
    test_walk();
    test_all_pending();
`else
    test_no_ped();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
